i2c_bus_arbiter: RTL and testbench
==================================

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter p_cmd_width, default 8, bit width of the I2C command word (t_i2c_cmd).
REQ-002 SHALL have parameter p_timeout_cycles, default 1000000, idle-owner timeout in i_clk cycles (used only with I2C_ARB_TIMEOUT_EN).
REQ-003 SHALL have port i_clk  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports i_reqN_valid  in  1, i_reqN_cmd  in  p_cmd_width, i_reqN_wr_data  in  8, i_reqN_last  in  1 (final command of transaction), o_reqN_ready  out  1; N = 0 (OV7670 config), 1 (MLX90640).
REQ-006 SHALL have ports o_reqN_rd_valid  out  1, i_reqN_rd_ready  in  1, o_rd_data  out  8 (shared read data), for N = 0, 1.
REQ-007 SHALL have master-side ports o_cmd_valid  out  1, o_cmd_data  out  p_cmd_width, o_wr_data  out  8, i_cmd_ready  in  1, i_rd_valid  in  1, i_rd_data  in  8, o_rd_ready  out  1, i_master_busy  in  1.
REQ-008 SHALL have status ports o_grant  out  2 (one-hot owner), o_timeout  out  1 (single-cycle pulse).

Function
REQ-009 SHALL implement FSM states IDLE, OWN0, OWN1, DRAIN.
REQ-010 IDLE: if exactly one i_reqN_valid is high, the next state SHALL be OWNN; if both are high, the requester not most recently served SHALL win.
REQ-011 Grant latency SHALL be one cycle: o_grant is registered, and no command passes through in IDLE; o_reqN_ready is 0 in IDLE.
REQ-012 In OWNN: o_cmd_valid = i_reqN_valid, o_cmd_data/o_wr_data = requester N fields, o_reqN_ready = i_cmd_ready; the other requester's ready SHALL be 0.
REQ-013 In OWNN, a handshake (valid & ready) with i_reqN_last = 1 SHALL move the FSM to DRAIN.
REQ-014 DRAIN: o_cmd_valid = 0 and all requester readies = 0; the FSM SHALL return to IDLE on the first cycle i_master_busy = 0.
REQ-015 The last-served pointer SHALL update on the DRAIN->IDLE transition to the released owner; its reset value SHALL be 1, so req0 wins the first tie.
REQ-016 Read routing: o_rd_data = i_rd_data; o_reqN_rd_valid = i_rd_valid & (rd_owner == N); o_rd_ready = i_reqN_rd_ready of rd_owner.
REQ-017 rd_owner SHALL be set on entry to OWNN and held through DRAIN.
REQ-018 In IDLE, o_rd_ready SHALL be 1 and read beats SHALL be discarded, so the master can never stall.
REQ-019 o_grant SHALL be 01 in OWN0, 10 in OWN1, held through DRAIN for the released owner, and 00 in IDLE.
REQ-020 A requester deasserting valid mid-transaction (before last) SHALL keep ownership; the grant SHALL NOT be preempted.

Reset
REQ-021 On i_rst_n = 0, the block SHALL asynchronously enter IDLE with o_grant = 00, o_timeout = 0, last-served = 1, rd_owner = 0, and the timeout counter = 0.
REQ-022 While reset is asserted, o_cmd_valid, o_reqN_ready and o_reqN_rd_valid SHALL be 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction with no further commands issued.

Configuration
REQ-024 With macro I2C_ARB_TIMEOUT_EN defined, an owner that completes no handshake for p_timeout_cycles consecutive cycles in OWNN SHALL be forced to DRAIN, with o_timeout pulsed for 1 cycle.
REQ-025 With I2C_ARB_TIMEOUT_EN defined, the timeout counter SHALL reset on every handshake and on every grant.
REQ-026 Without I2C_ARB_TIMEOUT_EN, o_timeout SHALL be tied 0, no counter SHALL exist, and ownership SHALL be held indefinitely.

Verification
REQ-027 Single requester: req0 sends 3 commands with last on the 3rd, i_cmd_ready = 1 -> o_grant = 01 one cycle after valid; 3 handshakes; DRAIN; IDLE once i_master_busy = 0.
REQ-028 Tie: both valid from reset -> req0 served first; on re-request by both after release -> req1 served; alternation holds over 4 transactions.
REQ-029 No preemption: req1 asserts valid while req0 owns and idles 10 cycles mid-transaction -> o_reqN_ready for req1 stays 0 until req0's last plus DRAIN completes.
REQ-030 Read path: req1 owns, master returns 2 read bytes 0xA5, 0x3C -> only o_req1_rd_valid pulses; o_rd_ready follows i_req1_rd_ready backpressure.
REQ-031 Reset mid-transaction: i_rst_n low during OWN0 after 1 of 3 commands -> o_grant = 00 and o_cmd_valid = 0 immediately; IDLE after release.
REQ-032 With I2C_ARB_TIMEOUT_EN and p_timeout_cycles = 16: req0 granted then silent -> o_timeout pulses at cycle 16; pending req1 granted after DRAIN.

Source files
------------

// File: rtl/i2c_bus_arbiter_if.sv
// Bundle of requester, read-return and I2C-master-side signals around the arbiter.
// Ports: two requester command/read channels plus the shared master command/read channel.
// Modports: master = arbiter view (drives o_*), slave = environment view (drives i_*).
interface i2c_bus_arbiter_if #(
   parameter int p_cmd_width = 8
);
   // requester 0 (OV7670 config)
   logic                   i_req0_valid;
   logic [p_cmd_width-1:0] i_req0_cmd;
   logic [7:0]             i_req0_wr_data;
   logic                   i_req0_last;
   logic                   o_req0_ready;
   logic                   o_req0_rd_valid;
   logic                   i_req0_rd_ready;
   // requester 1 (MLX90640)
   logic                   i_req1_valid;
   logic [p_cmd_width-1:0] i_req1_cmd;
   logic [7:0]             i_req1_wr_data;
   logic                   i_req1_last;
   logic                   o_req1_ready;
   logic                   o_req1_rd_valid;
   logic                   i_req1_rd_ready;
   // shared read data towards requesters
   logic [7:0]             o_rd_data;
   // I2C master engine side
   logic                   o_cmd_valid;
   logic [p_cmd_width-1:0] o_cmd_data;
   logic [7:0]             o_wr_data;
   logic                   i_cmd_ready;
   logic                   i_rd_valid;
   logic [7:0]             i_rd_data;
   logic                   o_rd_ready;
   logic                   i_master_busy;

   modport master (
      input  i_req0_valid, i_req0_cmd, i_req0_wr_data, i_req0_last, i_req0_rd_ready,
      input  i_req1_valid, i_req1_cmd, i_req1_wr_data, i_req1_last, i_req1_rd_ready,
      input  i_cmd_ready, i_rd_valid, i_rd_data, i_master_busy,
      output o_req0_ready, o_req0_rd_valid, o_req1_ready, o_req1_rd_valid, o_rd_data,
      output o_cmd_valid, o_cmd_data, o_wr_data, o_rd_ready
   );

   modport slave (
      output i_req0_valid, i_req0_cmd, i_req0_wr_data, i_req0_last, i_req0_rd_ready,
      output i_req1_valid, i_req1_cmd, i_req1_wr_data, i_req1_last, i_req1_rd_ready,
      output i_cmd_ready, i_rd_valid, i_rd_data, i_master_busy,
      input  o_req0_ready, o_req0_rd_valid, o_req1_ready, o_req1_rd_valid, o_rd_data,
      input  o_cmd_valid, o_cmd_data, o_wr_data, o_rd_ready
   );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Two-requester I2C bus arbiter: whole transactions granted, round-robin on ties.
// Latency: grant registered, one cycle after request; commands then pass combinationally.
// Backpressure: owner ready follows i_cmd_ready; non-owners held off until release.
// Ports: i_clk, i_rst_n (async active-low), bus (i2c_bus_arbiter_if.master),
//        o_grant (one-hot owner), o_timeout (one-cycle pulse).
// Optional: define I2C_ARB_TIMEOUT_EN to force release of an owner silent for
//           p_timeout_cycles cycles; otherwise ownership is held indefinitely.
module i2c_bus_arbiter #(
   parameter int p_cmd_width      = 8,
   parameter int p_timeout_cycles = 1000000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   i2c_bus_arbiter_if.master bus,
   output logic [1:0]        o_grant,
   output logic              o_timeout
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} t_state;

   t_state                 state_q, state_d;
   logic [1:0]             grant_q, grant_d;
   logic                   last_served_q;
   logic                   rd_owner_q;
   logic                   own_hs;
   logic                   to_expire;
   logic                   cmd_valid;
   logic [p_cmd_width-1:0] cmd_data;
   logic [7:0]             wr_data;
   logic                   req0_ready, req1_ready;
   logic                   in_idle;

   // handshake of the current owner; kept outside the FSM block so the
   // timeout logic can use it without a combinational feedback path
   assign own_hs = ((state_q == OWN0) && bus.i_req0_valid && bus.i_cmd_ready) ||
                   ((state_q == OWN1) && bus.i_req1_valid && bus.i_cmd_ready);

   always_comb begin
      state_d    = state_q;
      cmd_valid  = 1'b0;
      cmd_data   = '0;
      wr_data    = '0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            // on a tie the requester not served last wins
            if (bus.i_req0_valid && (!bus.i_req1_valid || last_served_q))
               state_d = OWN0;
            else if (bus.i_req1_valid)
               state_d = OWN1;
         end
         OWN0: begin
            cmd_valid  = bus.i_req0_valid;
            cmd_data   = bus.i_req0_cmd;
            wr_data    = bus.i_req0_wr_data;
            req0_ready = bus.i_cmd_ready;
            if ((own_hs && bus.i_req0_last) || to_expire)
               state_d = DRAIN;
         end
         OWN1: begin
            cmd_valid  = bus.i_req1_valid;
            cmd_data   = bus.i_req1_cmd;
            wr_data    = bus.i_req1_wr_data;
            req1_ready = bus.i_cmd_ready;
            if ((own_hs && bus.i_req1_last) || to_expire)
               state_d = DRAIN;
         end
         DRAIN: begin
            // wait for the master to finish the stop condition
            if (!bus.i_master_busy)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d = 2'b00;
      case (state_d)
         OWN0:    grant_d = 2'b01;
         OWN1:    grant_d = 2'b10;
         DRAIN:   grant_d = grant_q;
         default: grant_d = 2'b00;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         grant_q       <= 2'b00;
         last_served_q <= 1'b1;
         rd_owner_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         if (state_q == IDLE && state_d == OWN0)
            rd_owner_q <= 1'b0;
         else if (state_q == IDLE && state_d == OWN1)
            rd_owner_q <= 1'b1;
         // rd_owner still names the owner being released
         if (state_q == DRAIN && state_d == IDLE)
            last_served_q <= rd_owner_q;
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int lp_cnt_w = (p_timeout_cycles > 1) ? $clog2(p_timeout_cycles + 1) : 1;

   logic [lp_cnt_w-1:0] to_cnt_q;
   logic                timeout_q;
   logic                owning;

   assign owning    = (state_q == OWN0) || (state_q == OWN1);
   // fires on the p_timeout_cycles-th consecutive silent owner cycle
   assign to_expire = owning && !own_hs &&
                      (to_cnt_q == lp_cnt_w'(p_timeout_cycles - 1));
   assign o_timeout = timeout_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         // counter is zero outside ownership, so every grant starts from zero
         if (!owning || own_hs)
            to_cnt_q <= '0;
         else
            to_cnt_q <= to_cnt_q + lp_cnt_w'(1);
         timeout_q <= to_expire;
      end
   end
`else
   assign to_expire = 1'b0;
   assign o_timeout = 1'b0;
`endif

   assign in_idle = (state_q == IDLE);

   assign bus.o_cmd_valid  = cmd_valid;
   assign bus.o_cmd_data   = cmd_data;
   assign bus.o_wr_data    = wr_data;
   assign bus.o_req0_ready = req0_ready;
   assign bus.o_req1_ready = req1_ready;

   // read return: routed to the last granted owner; discarded while idle so
   // the master never stalls on an orphaned beat
   assign bus.o_rd_data       = bus.i_rd_data;
   assign bus.o_req0_rd_valid = bus.i_rd_valid && !in_idle && !rd_owner_q;
   assign bus.o_req1_rd_valid = bus.i_rd_valid && !in_idle && rd_owner_q;
   assign bus.o_rd_ready      = in_idle ? 1'b1 :
                                (rd_owner_q ? bus.i_req1_rd_ready : bus.i_req0_rd_ready);

   assign o_grant = grant_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed scenarios plus a randomized
// back-to-back run scored against a transaction-level arbitration model.
module tb_i2c_bus_arbiter;
   localparam int CW = 8;
   localparam int TO = 16;
   localparam int NT = 6;

   typedef struct packed {
      logic [CW-1:0] cmd;
      logic [7:0]    wr;
      logic          last;
      logic          owner;
   } ent_t;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [1:0] o_grant;
   logic       o_timeout;

   int vectors     = 0;
   int miscompares = 0;
   int model_last  = 1;

   always #5 i_clk = ~i_clk;

   i2c_bus_arbiter_if #(.p_cmd_width(CW)) bus ();

   i2c_bus_arbiter #(.p_cmd_width(CW), .p_timeout_cycles(TO)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .bus       (bus),
      .o_grant   (o_grant),
      .o_timeout (o_timeout)
   );

   task automatic idle_inputs();
      bus.i_req0_valid = 0; bus.i_req0_cmd = '0; bus.i_req0_wr_data = '0; bus.i_req0_last = 0;
      bus.i_req1_valid = 0; bus.i_req1_cmd = '0; bus.i_req1_wr_data = '0; bus.i_req1_last = 0;
      bus.i_req0_rd_ready = 0; bus.i_req1_rd_ready = 0;
      bus.i_cmd_ready = 0; bus.i_rd_valid = 0; bus.i_rd_data = '0; bus.i_master_busy = 0;
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n = 0;
      idle_inputs();
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1;
      model_last = 1;
   endtask

   task automatic test_reset();
      i_rst_n = 0;
      idle_inputs();
      // drive activity into the held-reset block: nothing may leak out
      bus.i_req0_valid = 1; bus.i_req1_valid = 1; bus.i_cmd_ready = 1; bus.i_rd_valid = 1;
      repeat (2) @(negedge i_clk);
      vectors++; if (o_grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant: got %b expected 00", o_grant); end
      vectors++; if (o_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b expected 0", o_timeout); end
      vectors++; if (bus.o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_valid: got %b expected 0", bus.o_cmd_valid); end
      vectors++; if ({bus.o_req0_ready, bus.o_req1_ready} !== 2'b00) begin miscompares++; $display("FAIL rst_ready: got %b expected 00", {bus.o_req0_ready, bus.o_req1_ready}); end
      vectors++; if ({bus.o_req0_rd_valid, bus.o_req1_rd_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_rd_valid: got %b expected 00", {bus.o_req0_rd_valid, bus.o_req1_rd_valid}); end
      idle_inputs();
      @(posedge i_clk); #1 i_rst_n = 1;
      model_last = 1;
      @(negedge i_clk);
      vectors++; if (o_grant !== 2'b00) begin miscompares++; $display("FAIL post_rst_grant: got %b expected 00", o_grant); end
      vectors++; if (bus.o_rd_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_rd_ready: got %b expected 1", bus.o_rd_ready); end
   endtask

   task automatic test_single();
      logic [CW-1:0] c [3];
      logic [7:0]    w [3];
      for (int k = 0; k < 3; k++) begin c[k] = CW'($urandom); w[k] = 8'($urandom); end
      cyc();
      bus.i_req0_valid = 1; bus.i_req0_cmd = c[0]; bus.i_req0_wr_data = w[0]; bus.i_req0_last = 0;
      bus.i_cmd_ready = 1; bus.i_master_busy = 1;
      @(negedge i_clk);
      vectors++; if (o_grant !== 2'b00) begin miscompares++; $display("FAIL single_idle_grant: got %b expected 00", o_grant); end
      vectors++; if (bus.o_req0_ready !== 1'b0 || bus.o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle_pass: got ready %b valid %b expected 0 0", bus.o_req0_ready, bus.o_cmd_valid); end
      for (int k = 0; k < 3; k++) begin
         cyc();
         bus.i_req0_cmd = c[k]; bus.i_req0_wr_data = w[k]; bus.i_req0_last = (k == 2);
         @(negedge i_clk);
         vectors++; if (o_grant !== 2'b01) begin miscompares++; $display("FAIL single_grant[%0d]: got %b expected 01", k, o_grant); end
         vectors++; if (bus.o_cmd_valid !== 1'b1 || bus.o_cmd_data !== c[k] || bus.o_wr_data !== w[k]) begin miscompares++; $display("FAIL single_cmd[%0d]: got %b %h %h expected 1 %h %h", k, bus.o_cmd_valid, bus.o_cmd_data, bus.o_wr_data, c[k], w[k]); end
         vectors++; if (bus.o_req0_ready !== 1'b1 || bus.o_req1_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready[%0d]: got %b%b expected 10", k, bus.o_req0_ready, bus.o_req1_ready); end
      end
      for (int k = 0; k < 3; k++) begin
         cyc();
         bus.i_req0_valid = 1; bus.i_req0_cmd = CW'($urandom); bus.i_req0_last = 0;
         @(negedge i_clk);
         vectors++; if (bus.o_cmd_valid !== 1'b0 || bus.o_req0_ready !== 1'b0) begin miscompares++; $display("FAIL drain_block[%0d]: got valid %b ready %b expected 0 0", k, bus.o_cmd_valid, bus.o_req0_ready); end
         vectors++; if (o_grant !== 2'b01) begin miscompares++; $display("FAIL drain_grant[%0d]: got %b expected 01", k, o_grant); end
      end
      cyc();
      bus.i_req0_valid = 0; bus.i_master_busy = 0;
      @(negedge i_clk);
      vectors++; if (o_grant !== 2'b01) begin miscompares++; $display("FAIL drain_last_grant: got %b expected 01", o_grant); end
      cyc();
      @(negedge i_clk);
      vectors++; if (o_grant !== 2'b00) begin miscompares++; $display("FAIL single_release: got %b expected 00", o_grant); end
      model_last = 0;
   endtask

   task automatic test_tie();
      int  win;
      bit  got;
      do_reset();
      for (int t = 0; t < 4; t++) begin
         win = 1 - model_last;
         cyc();
         bus.i_req0_valid = 1; bus.i_req0_cmd = CW'(8'h10 + t); bus.i_req0_last = 1;
         bus.i_req1_valid = 1; bus.i_req1_cmd = CW'(8'h20 + t); bus.i_req1_last = 1;
         bus.i_cmd_ready = 1; bus.i_master_busy = 0;
         got = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            if (o_grant !== 2'b00) begin got = 1; break; end
         end
         vectors++;
         if (!got) begin miscompares++; $display("FAIL tie_wait[%0d]: got no grant expected grant within 8 cycles", t); end
         else if (o_grant !== (win ? 2'b10 : 2'b01) || bus.o_cmd_data !== CW'((win ? 8'h20 : 8'h10) + t)) begin
            miscompares++; $display("FAIL tie_winner[%0d]: got %b %h expected req%0d", t, o_grant, bus.o_cmd_data, win);
         end
         vectors++; if ((win ? bus.o_req0_ready : bus.o_req1_ready) !== 1'b0) begin miscompares++; $display("FAIL tie_loser_ready[%0d]: got 1 expected 0", t); end
         cyc();
         if (win) bus.i_req1_valid = 0; else bus.i_req0_valid = 0;
         model_last = win;
      end
      cyc();
      idle_inputs();
      repeat (3) cyc();
   endtask

   task automatic test_no_preempt();
      bit got;
      do_reset();
      cyc();
      bus.i_req0_valid = 1; bus.i_req0_cmd = 8'hA1; bus.i_req0_last = 0;
      bus.i_req1_valid = 1; bus.i_req1_cmd = 8'hB1; bus.i_req1_last = 1;
      bus.i_cmd_ready = 1; bus.i_master_busy = 1;
      got = 0;
      for (int i = 0; i < 8; i++) begin @(negedge i_clk); if (o_grant !== 2'b00) begin got = 1; break; end end
      vectors++; if (!got || o_grant !== 2'b01 || bus.o_cmd_data !== 8'hA1) begin miscompares++; $display("FAIL np_first: got %b %h expected 01 a1", o_grant, bus.o_cmd_data); end
      for (int i = 0; i < 10; i++) begin
         cyc();
         bus.i_req0_valid = 0;
         @(negedge i_clk);
         vectors++; if (bus.o_req1_ready !== 1'b0 || o_grant !== 2'b01 || bus.o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL np_hold[%0d]: got ready1 %b grant %b valid %b expected 0 01 0", i, bus.o_req1_ready, o_grant, bus.o_cmd_valid); end
      end
      cyc();
      bus.i_req0_valid = 1; bus.i_req0_cmd = 8'hA2; bus.i_req0_last = 1;
      @(negedge i_clk);
      vectors++; if (bus.o_cmd_data !== 8'hA2 || bus.o_req0_ready !== 1'b1 || bus.o_req1_ready !== 1'b0) begin miscompares++; $display("FAIL np_last: got %h %b%b expected a2 10", bus.o_cmd_data, bus.o_req0_ready, bus.o_req1_ready); end
      for (int i = 0; i < 2; i++) begin
         cyc();
         bus.i_req0_valid = 0;
         @(negedge i_clk);
         vectors++; if (bus.o_req1_ready !== 1'b0 || o_grant !== 2'b01) begin miscompares++; $display("FAIL np_drain[%0d]: got ready1 %b grant %b expected 0 01", i, bus.o_req1_ready, o_grant); end
      end
      cyc();
      bus.i_master_busy = 0;
      got = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge i_clk);
         if (o_grant === 2'b10) begin got = 1; break; end
         vectors++; if (bus.o_req1_ready !== 1'b0) begin miscompares++; $display("FAIL np_early_ready: got 1 expected 0"); end
      end
      vectors++; if (!got || bus.o_req1_ready !== 1'b1 || bus.o_cmd_data !== 8'hB1) begin miscompares++; $display("FAIL np_req1: got %b %b %h expected 10 1 b1", o_grant, bus.o_req1_ready, bus.o_cmd_data); end
      cyc();
      idle_inputs();
      repeat (3) cyc();
   endtask

   task automatic test_read();
      logic [7:0] bytes [2];
      int idx;
      bit got;
      bytes[0] = 8'hA5; bytes[1] = 8'h3C;
      do_reset();
      cyc();
      bus.i_req1_valid = 1; bus.i_req1_cmd = 8'h33; bus.i_req1_last = 1;
      bus.i_cmd_ready = 1; bus.i_master_busy = 1;
      got = 0;
      for (int i = 0; i < 8; i++) begin @(negedge i_clk); if (o_grant !== 2'b00) begin got = 1; break; end end
      vectors++; if (!got || o_grant !== 2'b10) begin miscompares++; $display("FAIL rd_grant: got %b expected 10", o_grant); end
      cyc();
      bus.i_req1_valid = 0;
      idx = 0;
      for (int i = 0; i < 60 && idx < 2; i++) begin
         cyc();
         bus.i_rd_valid = 1; bus.i_rd_data = bytes[idx];
         bus.i_req1_rd_ready = 1'($urandom_range(0, 1));
         bus.i_req0_rd_ready = 1'($urandom_range(0, 1));
         @(negedge i_clk);
         vectors++; if (bus.o_req1_rd_valid !== 1'b1 || bus.o_req0_rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_route[%0d]: got %b%b expected 01", idx, bus.o_req0_rd_valid, bus.o_req1_rd_valid); end
         vectors++; if (bus.o_rd_data !== bytes[idx]) begin miscompares++; $display("FAIL rd_data[%0d]: got %h expected %h", idx, bus.o_rd_data, bytes[idx]); end
         vectors++; if (bus.o_rd_ready !== bus.i_req1_rd_ready) begin miscompares++; $display("FAIL rd_ready[%0d]: got %b expected %b", idx, bus.o_rd_ready, bus.i_req1_rd_ready); end
         if (bus.i_req1_rd_ready) idx++;
      end
      vectors++; if (idx != 2) begin miscompares++; $display("FAIL rd_beats: got %0d expected 2", idx); end
      cyc();
      bus.i_rd_valid = 0; bus.i_master_busy = 0; bus.i_req0_rd_ready = 0; bus.i_req1_rd_ready = 0;
      cyc();
      cyc();
      bus.i_rd_valid = 1; bus.i_rd_data = 8'h77;
      @(negedge i_clk);
      vectors++; if (bus.o_rd_ready !== 1'b1 || {bus.o_req0_rd_valid, bus.o_req1_rd_valid} !== 2'b00) begin miscompares++; $display("FAIL rd_idle_discard: got ready %b rv %b%b expected 1 00", bus.o_rd_ready, bus.o_req0_rd_valid, bus.o_req1_rd_valid); end
      cyc();
      idle_inputs();
      model_last = 1;
   endtask

   task automatic test_reset_mid();
      bit got;
      do_reset();
      cyc();
      bus.i_req0_valid = 1; bus.i_req0_cmd = 8'h51; bus.i_req0_last = 0;
      bus.i_cmd_ready = 1; bus.i_master_busy = 1;
      got = 0;
      for (int i = 0; i < 8; i++) begin @(negedge i_clk); if (o_grant !== 2'b00) begin got = 1; break; end end
      vectors++; if (!got || o_grant !== 2'b01) begin miscompares++; $display("FAIL rm_grant: got %b expected 01", o_grant); end
      cyc();
      bus.i_req0_cmd = 8'h52; bus.i_cmd_ready = 0;
      @(negedge i_clk);
      vectors++; if (bus.o_cmd_valid !== 1'b1) begin miscompares++; $display("FAIL rm_owning: got %b expected 1", bus.o_cmd_valid); end
      #1 i_rst_n = 0;
      #1;
      vectors++; if (o_grant !== 2'b00 || bus.o_cmd_valid !== 1'b0 || bus.o_req0_ready !== 1'b0) begin miscompares++; $display("FAIL rm_async: got grant %b valid %b ready %b expected 00 0 0", o_grant, bus.o_cmd_valid, bus.o_req0_ready); end
      bus.i_req0_valid = 0; bus.i_cmd_ready = 0;
      @(negedge i_clk);
      i_rst_n = 1;
      model_last = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         vectors++; if (o_grant !== 2'b00 || bus.o_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rm_after[%0d]: got %b %b expected 00 0", i, o_grant, bus.o_cmd_valid); end
      end
      idle_inputs();
   endtask

   task automatic test_timeout();
      bit got;
      int n;
      do_reset();
      cyc();
      bus.i_req0_valid = 1; bus.i_req0_cmd = 8'h61; bus.i_req0_last = 0;
      bus.i_req1_valid = 1; bus.i_req1_cmd = 8'h71; bus.i_req1_last = 1;
      bus.i_cmd_ready = 1; bus.i_master_busy = 1;
      cyc();
      bus.i_req0_valid = 0;
      @(negedge i_clk);
      vectors++; if (o_grant !== 2'b01) begin miscompares++; $display("FAIL to_grant: got %b expected 01", o_grant); end
`ifdef I2C_ARB_TIMEOUT_EN
      n = 0; got = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge i_clk);
         n++;
         if (o_timeout === 1'b1) begin got = 1; break; end
      end
      vectors++; if (!got || n != TO) begin miscompares++; $display("FAIL to_pulse_cycle: got %0d expected %0d", n, TO); end
      @(negedge i_clk);
      vectors++; if (o_timeout !== 1'b0) begin miscompares++; $display("FAIL to_single_pulse: got %b expected 0", o_timeout); end
`else
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge i_clk);
         vectors++; if (o_timeout !== 1'b0 || o_grant !== 2'b01 || bus.o_req1_ready !== 1'b0) begin miscompares++; $display("FAIL to_held[%0d]: got to %b grant %b ready1 %b expected 0 01 0", i, o_timeout, o_grant, bus.o_req1_ready); end
      end
      cyc();
      bus.i_req0_valid = 1; bus.i_req0_last = 1;
      cyc();
      bus.i_req0_valid = 0;
`endif
      cyc();
      bus.i_master_busy = 0;
      got = 0;
      for (int i = 0; i < 8; i++) begin @(negedge i_clk); if (o_grant === 2'b10) begin got = 1; break; end end
      vectors++; if (!got || bus.o_cmd_data !== 8'h71) begin miscompares++; $display("FAIL to_next_owner: got %b %h expected 10 71", o_grant, bus.o_cmd_data); end
      cyc();
      idle_inputs();
      repeat (3) cyc();
   endtask

   task automatic test_back_to_back();
      ent_t f0[$], f1[$], exp_q[$];
      ent_t e;
      int   p0, p1, i0, i1, last, pick;
      bit   v0, v1, h0, h1, done;
      int   len;
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int t = 0; t < NT; t++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
               e.cmd = CW'($urandom); e.wr = 8'($urandom); e.last = (k == len - 1); e.owner = r[0];
               if (r == 0) f0.push_back(e); else f1.push_back(e);
            end
         end
      // transaction order: alternate while both have work, starting with the one not served last
      p0 = 0; p1 = 0; last = model_last;
      while (p0 < f0.size() || p1 < f1.size()) begin
         if (p0 < f0.size() && p1 < f1.size()) pick = 1 - last;
         else pick = (p0 < f0.size()) ? 0 : 1;
         do begin
            e = pick ? f1[p1] : f0[p0];
            if (pick) p1++; else p0++;
            exp_q.push_back(e);
         end while (!e.last);
         last = pick;
      end
      i0 = 0; i1 = 0; done = 0;
      for (int c = 0; c < 4000 && !done; c++) begin
         cyc();
         v0 = (i0 < f0.size()); v1 = (i1 < f1.size());
         bus.i_req0_valid = v0;
         if (v0) begin bus.i_req0_cmd = f0[i0].cmd; bus.i_req0_wr_data = f0[i0].wr; bus.i_req0_last = f0[i0].last; end
         bus.i_req1_valid = v1;
         if (v1) begin bus.i_req1_cmd = f1[i1].cmd; bus.i_req1_wr_data = f1[i1].wr; bus.i_req1_last = f1[i1].last; end
         bus.i_cmd_ready   = ($urandom_range(0, 3) != 0);
         bus.i_master_busy = ($urandom_range(0, 2) == 0);
         @(negedge i_clk);
         h0 = v0 && bus.o_req0_ready;
         h1 = v1 && bus.o_req1_ready;
         if (bus.o_req0_ready && bus.o_req1_ready) begin vectors++; miscompares++; $display("FAIL b2b_both_ready: got 11 expected at most one"); end
         if (bus.o_cmd_valid && bus.i_cmd_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL b2b_extra_cmd: got %h expected none", bus.o_cmd_data); end
            else begin
               e = exp_q.pop_front();
               if (bus.o_cmd_data !== e.cmd || bus.o_wr_data !== e.wr || o_grant !== (e.owner ? 2'b10 : 2'b01) || (e.owner ? h1 : h0) !== 1'b1) begin
                  miscompares++;
                  $display("FAIL b2b_cmd: got %h %h grant %b expected %h %h req%0d", bus.o_cmd_data, bus.o_wr_data, o_grant, e.cmd, e.wr, e.owner);
               end
            end
         end
         if (h0) i0++;
         if (h1) i1++;
         done = (i0 == f0.size()) && (i1 == f1.size());
      end
      vectors++; if (!done || exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_complete: got %0d cmds left expected 0", exp_q.size()); end
      cyc();
      idle_inputs();
      repeat (3) @(negedge i_clk);
      vectors++; if (o_grant !== 2'b00) begin miscompares++; $display("FAIL b2b_final_idle: got %b expected 00", o_grant); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_no_preempt();
      test_read();
      test_reset_mid();
      test_timeout();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
